// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle for ifid_queue.
// slave = queue side, master = fetch/decode environment side.
interface ifid_queue_if #(
  parameter int CNT_W = 16
);
  logic             if_valid_in;
  logic             if_halt_in;
  logic [31:0]      if_pc_in;
  logic [31:0]      if_pc4_in;
  logic [31:0]      if_instr_in;
  logic             if_ready_out;
  logic             flush_in;
  logic             id_ready_in;
  logic             id_valid_out;
  logic             id_halt_out;
  logic [31:0]      id_pc_out;
  logic [31:0]      id_pc4_out;
  logic [31:0]      id_instr_out;
  logic [CNT_W-1:0] stall_cnt_out;

  modport slave (
    input  if_valid_in, if_halt_in,
    input  if_pc_in, if_pc4_in, if_instr_in,
    input  flush_in, id_ready_in,
    output if_ready_out, id_valid_out,
    output id_halt_out, id_pc_out,
    output id_pc4_out, id_instr_out,
    output stall_cnt_out
  );

  modport master (
    output if_valid_in, if_halt_in,
    output if_pc_in, if_pc4_in, if_instr_in,
    output flush_in, id_ready_in,
    input  if_ready_out, id_valid_out,
    input  id_halt_out, id_pc_out,
    input  id_pc4_out, id_instr_out,
    input  stall_cnt_out
  );
endinterface

// File: rtl/ifid_queue.sv
// IF->ID decoupling FIFO with flush, halt blocking and stall counter.
// Define IFID_BYPASS_EN for a zero-latency bypass when the queue is empty.
module ifid_queue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  ifid_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t             mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic empty, ready, valid;
  logic acc, byp, push, pop, stall;
  ent_t in_e, head_e, out_e;

  assign in_e  = {bus.if_halt_in, bus.if_pc_in,
                  bus.if_pc4_in, bus.if_instr_in};
  assign empty = (cnt_q == '0);
  // Registered count only: a same-cycle pop never frees a slot.
  assign ready = ~rst & (cnt_q < FULL) & ~halt_q;
  assign acc   = bus.if_valid_in & ready & ~bus.flush_in;

`ifdef IFID_BYPASS_EN
  assign byp = acc & empty & bus.id_ready_in;
`else
  assign byp = 1'b0;
`endif

  assign push   = acc & ~byp;
  assign pop    = ~empty & bus.id_ready_in & ~bus.flush_in;
  assign valid  = ~empty | byp;
  assign stall  = valid & ~bus.id_ready_in;
  assign head_e = empty ? '0 : mem_q[rd_q];
  assign out_e  = byp ? in_e : head_e;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    stall_d = stall_q;
    if (stall && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (bus.flush_in) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      halt_d = 1'b0;
    end else begin
      if (push)
        wr_d = wr_q + AW'(1);
      if (pop)
        rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push)
                    - (AW+1)'(pop);
      // A bypassed halt blocks fetch too.
      if (acc & bus.if_halt_in)
        halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= in_e;
  end

  assign bus.if_ready_out  = ready;
  assign bus.id_valid_out  = valid;
  assign bus.id_halt_out   = out_e.halt;
  assign bus.id_pc_out     = out_e.pc;
  assign bus.id_pc4_out    = out_e.pc4;
  assign bus.id_instr_out  = out_e.instr;
  assign bus.stall_cnt_out = stall_q;
endmodule

// File: doc/ifid_queue.md
# ifid_queue

Decoupling queue between the instruction-fetch stage and the decode stage of the pipelined CPU. It captures each fetched {pc, pc+4, instruction, halt} tuple into a small FIFO and presents the oldest entry to decode with a valid/ready handshake. It absorbs decode stalls without re-fetching, discards wrong-path entries on a branch/jump flush, and blocks fetch after a halting instruction. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- CNT_W, 16, width of stall counter
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- if_valid_in  in  1  fetch presents an entry this cycle
- if_halt_in  in  1  entry is halting (halt request or unaligned PC)
- if_pc_in  in  32  entry PC
- if_pc4_in  in  32  entry PC+4
- if_instr_in  in  32  entry instruction word
- if_ready_out  out  1  queue accepts an entry this cycle; fetch advances PC only when valid&ready
- flush_in  in  1  branch taken / jump redirect; discard all entries
- id_ready_in  in  1  decode consumes head this cycle
- id_valid_out  out  1  head entry valid
- id_halt_out, id_pc_out, id_pc4_out, id_instr_out  out  1/32/32/32  head entry fields
- stall_cnt_out  out  CNT_W  cycles with id_valid_out=1 and id_ready_in=0, saturating

## Operation
- Storage: DEPTH-entry circular buffer, rd_ptr/wr_ptr of log2(DEPTH) bits that wrap naturally; occupancy counter of log2(DEPTH)+1 bits.
- Push = if_valid_in & if_ready_out & ~flush_in. Pop = id_valid_out & id_ready_in & ~flush_in.
- if_ready_out = ~rst & (count < DEPTH) & ~halt_seen. Uses registered count only; a pop in the same cycle does not open a slot for a push when full.
- id_valid_out = (count != 0); data outputs are the head entry. When empty, data outputs are 0.
- Push & pop in the same cycle: count unchanged, both pointers advance.
- halt_seen: set when a pushed entry has if_halt_in=1. While set, if_ready_out=0. The halt entry and any older entries still drain to decode.
- Flush: highest priority. Next cycle count=0, pointers=0, and halt_seen cleared, because the halt may be on the wrong path. Push/pop on the flush cycle are ignored.
- stall_cnt_out increments by 1 each cycle with id_valid_out & ~id_ready_in. It holds at 2^CNT_W−1 and is unaffected by flush.

## Timing
- Reset (async assert, sync-free deassert), immediately and while rst=1:
  - count=0, pointers=0, halt_seen=0, stall_cnt_out=0
  - id_valid_out=0, all id_* data=0, if_ready_out=0
  - if_ready_out=1 in the first cycle after rst deasserts.
- Latency: an entry pushed at edge N is visible on id_* after edge N (registered). One cycle minimum from fetch to decode unless bypass is enabled.
- Throughput: 1 entry/cycle sustained when id_ready_in=1 and DEPTH≥2.
- Reset mid-operation: all entries are lost and the counter is cleared with no partial state.

## Configuration
- IFID_BYPASS_EN defined:
  - When count=0, if_valid_in=1, id_ready_in=1, ~flush_in, the input drives id_* combinationally with id_valid_out=1. The entry is not stored and pointers do not move; this is zero latency.
  - A bypassed halt entry still sets halt_seen.
  - A bypass cycle never counts as a stall.
- IFID_BYPASS_EN undefined:
  - No combinational path from if_* to id_*.
  - Minimum latency is 1 cycle.

## Test plan
- Reset then stream: pcs 0x0,0x4,0x8 with id_ready_in=1 -> id_pc_out 0x0,0x4,0x8 on consecutive cycles (1-cycle lag without bypass); stall_cnt_out=0.
- Back-pressure: DEPTH=2, id_ready_in=0, push 0x10,0x14 -> if_ready_out=0 after 2nd push, stall_cnt_out counts up. Release -> 0x10 then 0x14 in order, and a new push accepted the cycle after the first pop.
- Flush with 2 entries plus a concurrent push of 0x20 -> next cycle id_valid_out=0, count=0, 0x20 dropped, if_ready_out=1.
- Halt: push 0x8 with if_halt_in=1 -> if_ready_out stays 0. Entry 0x8 emitted with id_halt_out=1. A later flush_in re-enables if_ready_out.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt_out=15. Async rst mid-cycle -> stall_cnt_out=0 and id_valid_out=0 before the next edge.
- Bypass (IFID_BYPASS_EN): empty, push 0x40 with id_ready_in=1 -> id_pc_out=0x40 in the same cycle, count stays 0.
